fetch_unit: RTL and testbench

//  Parametrised fetch stage: holds the fetch PC and issues in-order requests to an instruction memory with a
//  gnt/rvalid handshake. Keeps up to BUF_DEPTH requests in flight, and buffers returned instructions (with PC)
//  in a FIFO. Drives a valid/ready interface to decode. Supports branch redirect (flush plus stale-response drop)
//  and halt. Sits between the PC/memory subsystem and decode.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Fetch stage between the PC/instruction-memory side and decode. Holds the
//   fetch PC, issues in-order requests under a gnt/rvalid handshake, keeps up
//   to BUF_DEPTH requests in flight, and buffers returned instructions together
//   with their PC in a FIFO. It also handles branch redirect (flush and drop of
//   stale responses) and halt.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   redirect_valid, redirect_pc redirect fetch to redirect_pc
//   halt                        suppress new requests while high
//   imem_req, imem_addr         request to instruction memory (addr = fetch PC)
//   imem_gnt                    memory accepts the request this cycle
//   imem_rvalid, imem_rdata     in-order response from memory
//   out_valid, out_instr        head instruction offered to decode
//   out_pc, out_pc_next         PC of head instruction and PC + INSTR_BYTES
//   out_ready                   decode accepts the head instruction
module fetch_unit #(
   parameter int unsigned       DATA_W      = 16,
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       INSTR_BYTES = 2,
   parameter int unsigned       BUF_DEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_next,
   input  logic              out_ready
);

   localparam int unsigned       PW      = $clog2(BUF_DEPTH);
   localparam int unsigned       CW      = PW + 1;
   localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(INSTR_BYTES);
   localparam logic [CW:0]       DEPTH_C = (CW+1)'(BUF_DEPTH);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CW-1:0]     infl_q, infl_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [PW-1:0]     fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

   logic [ADDR_W-1:0] tag_q        [BUF_DEPTH];
   logic [DATA_W-1:0] fifo_instr_q [BUF_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_q    [BUF_DEPTH];

   logic credit_ok;
   logic grant;
   logic push;
   logic pop;

   // In-flight count includes responses still to be dropped, so FIFO entries
   // plus in-flight requests can never exceed the FIFO capacity.
   assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_C;
   assign imem_req  = ~rst & (state_q == ST_FETCH) & ~halt & credit_ok;
   assign imem_addr = pc_q;
   assign grant     = imem_req & imem_gnt;

   assign out_valid   = (cnt_q != '0);
   assign out_instr   = fifo_instr_q[fifo_rd_q];
   assign out_pc      = fifo_pc_q[fifo_rd_q];
   assign out_pc_next = out_pc + PC_INC;

   assign pop  = out_valid & out_ready;
   // A response is stored only when nothing is pending drop and no redirect
   // is happening in the same cycle.
   assign push = imem_rvalid & (drop_q == '0) & ~redirect_valid;

   always_comb begin
      infl_d    = infl_q + CW'(grant) - CW'(imem_rvalid);
      tag_wr_d  = tag_wr_q + PW'(grant);
      tag_rd_d  = tag_rd_q + PW'(imem_rvalid);
      pc_d      = grant ? (pc_q + PC_INC) : pc_q;
      drop_d    = (imem_rvalid && (drop_q != '0)) ? (drop_q - CW'(1)) : drop_q;
      fifo_wr_d = fifo_wr_q + PW'(push);
      fifo_rd_d = fifo_rd_q + PW'(pop);
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      if (redirect_valid) begin
         // The head transfer in this cycle (if any) has already left; the rest
         // of the FIFO is discarded and every request still outstanding after
         // this cycle's grant/response is marked to drop.
         pc_d      = redirect_pc;
         drop_d    = infl_d;
         fifo_wr_d = '0;
         fifo_rd_d = '0;
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         infl_q    <= '0;
         drop_q    <= '0;
         cnt_q     <= '0;
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         fifo_wr_q <= '0;
         fifo_rd_q <= '0;
      end else begin
         case (state_q)
            ST_FETCH: if (halt)  state_q <= ST_HALT;
            ST_HALT:  if (!halt) state_q <= ST_FETCH;
            default:             state_q <= ST_FETCH;
         endcase
         pc_q      <= pc_d;
         infl_q    <= infl_d;
         drop_q    <= drop_d;
         cnt_q     <= cnt_d;
         tag_wr_q  <= tag_wr_d;
         tag_rd_q  <= tag_rd_d;
         fifo_wr_q <= fifo_wr_d;
         fifo_rd_q <= fifo_rd_d;
      end
   end

   // Storage arrays: no reset needed, validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_q[tag_wr_q] <= pc_q;
      end
      if (push) begin
         fifo_instr_q[fifo_wr_q] <= imem_rdata;
         fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
      end
   end

   // Responses return in request order, so one without an outstanding
   // request means the memory side is broken.
   a_rvalid_has_req: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (infl_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed checks of fetch_unit: reset, streaming, backpressure/credits,
//   redirect flush and drop, halt, PC wrap, plus a randomised stream checked
//   against a simple expected-PC model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic [15:0] out_pc_next;
   logic        out_ready;

   logic        w_req;
   logic [15:0] w_addr;
   logic        w_gnt;
   logic        w_rvalid;
   logic [15:0] w_rdata;
   logic        w_ov;
   logic [15:0] w_instr;
   logic [15:0] w_pc;
   logic [15:0] w_next;
   logic        w_ready;

   int n_total = 0;
   int n_bad   = 0;

   logic        s_req;
   logic [15:0] s_addr;
   logic        s_ov;
   logic [15:0] s_pc;
   logic [15:0] s_instr;
   logic [15:0] s_next;

   logic [15:0] mq[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_next    (out_pc_next),
      .out_ready      (out_ready)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (1'b0),
      .redirect_pc    (16'h0000),
      .halt           (1'b0),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_gnt       (w_gnt),
      .imem_rvalid    (w_rvalid),
      .imem_rdata     (w_rdata),
      .out_valid      (w_ov),
      .out_instr      (w_instr),
      .out_pc         (w_pc),
      .out_pc_next    (w_next),
      .out_ready      (w_ready)
   );

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_w_req", w_req, 1'b0);
      rst = 1'b0;
      mq.delete();
   endtask

   // One clock cycle on the main DUT: drive inputs, capture outputs, then
   // update the memory model with this cycle's grant/response.
   task automatic cyc(input logic g, input logic rv, input logic rdy,
                      input logic rd, input logic [15:0] rpc, input logic h);
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = (rv && mq.size() != 0) ? instr_of(mq[0]) : 16'h0000;
      out_ready      = rdy;
      redirect_valid = rd;
      redirect_pc    = rpc;
      halt           = h;
      #1;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_ov    = out_valid;
      s_pc    = out_pc;
      s_instr = out_instr;
      s_next  = out_pc_next;
      if (rv && mq.size() != 0) void'(mq.pop_front());
      if (imem_req && g) mq.push_back(imem_addr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   initial begin
      int          ngr;
      logic [15:0] exp_pc;
      logic        hstate;
      logic        g, rv, rdy, rd;
      logic [31:0] r;
      logic [15:0] rpc;

      // T1: streaming from reset
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, k >= 1, 1'b1, 1'b0, 16'h0, 1'b0);
         chk("t1_req", s_req, 1'b1);
         chk("t1_addr", s_addr, 16'(2 * k));
         if (k >= 2) begin
            chk("t1_ov", s_ov, 1'b1);
            chk("t1_pc", s_pc, 16'(2 * (k - 2)));
            chk("t1_instr", s_instr, instr_of(16'(2 * (k - 2))));
            chk("t1_next", s_next, 16'(2 * (k - 2) + 2));
         end else begin
            chk("t1_ov0", s_ov, 1'b0);
         end
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t1_drain_pc8", s_pc, 16'h0008);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t1_drain_pc10", s_pc, 16'h000A);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t1_empty", s_ov, 1'b0);

      // T2: backpressure limits grants to the FIFO depth
      do_reset();
      ngr = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, (k >= 1) && (k <= 4), 1'b0, 1'b0, 16'h0, 1'b0);
         if (s_req) ngr++;
      end
      chk("t2_grants", ngr, 4);
      chk("t2_req_off", s_req, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t2_pop_pc", s_pc, 16'h0000);
      chk("t2_req_full", s_req, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("t2_credit_req", s_req, 1'b1);
      chk("t2_credit_addr", s_addr, 16'h0008);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("t2_req_full2", s_req, 1'b0);
      for (int j = 0; j < 4; j++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
         chk("t2_drain_pc", s_pc, 16'(2 + 2 * j));
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t2_empty", s_ov, 1'b0);

      // T3: redirect flushes the FIFO and drops outstanding responses
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
      chk("t3_req_full", s_req, 1'b0);
      chk("t3_stall_ov", s_ov, 1'b1);
      chk("t3_stall_pc", s_pc, 16'h0000);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t3_flushed", s_ov, 1'b0);
      chk("t3_new_req", s_req, 1'b1);
      chk("t3_new_addr", s_addr, 16'h0100);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t3_drop2", s_ov, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t3_nobypass", s_ov, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t3_first_ov", s_ov, 1'b1);
      chk("t3_first_pc", s_pc, 16'h0100);
      chk("t3_first_instr", s_instr, instr_of(16'h0100));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t3_empty", s_ov, 1'b0);

      // T4: redirect with same-cycle transfer, grant and response
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0);
      chk("t4_xfer_ov", s_ov, 1'b1);
      chk("t4_xfer_pc", s_pc, 16'h0000);
      chk("t4_r_req", s_req, 1'b1);
      chk("t4_r_addr", s_addr, 16'h0004);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t4_no_redeliver", s_ov, 1'b0);
      chk("t4_next_addr", s_addr, 16'h0200);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t4_wait", s_ov, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t4_first_pc", s_pc, 16'h0200);
      chk("t4_first_ov", s_ov, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t4_empty", s_ov, 1'b0);

      // T5: halt with two requests in flight
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
      chk("t5_halt_req", s_req, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
      chk("t5_halt_req2", s_req, 1'b0);
      chk("t5_pc0", s_pc, 16'h0000);
      chk("t5_ov0", s_ov, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
      chk("t5_halt_req3", s_req, 1'b0);
      chk("t5_pc2", s_pc, 16'h0002);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t5_exit_bubble", s_req, 1'b0);
      chk("t5_drained", s_ov, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t5_resume_req", s_req, 1'b1);
      chk("t5_resume_addr", s_addr, 16'h0004);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("t5_resume_pc", s_pc, 16'h0004);

      // T6: PC wrap on the RESET_PC=0xFFFE instance
      do_reset();
      w_gnt = 1'b1;
      #1;
      chk("t6_req", w_req, 1'b1);
      chk("t6_addr0", w_addr, 16'hFFFE);
      @(posedge clk); #1;
      w_rvalid = 1'b1; w_rdata = instr_of(16'hFFFE);
      #1;
      chk("t6_addr1", w_addr, 16'h0000);
      @(posedge clk); #1;
      w_gnt = 1'b0; w_rdata = instr_of(16'h0000); w_ready = 1'b1;
      #1;
      chk("t6_ov", w_ov, 1'b1);
      chk("t6_pc", w_pc, 16'hFFFE);
      chk("t6_next_wrap", w_next, 16'h0000);
      chk("t6_instr", w_instr, instr_of(16'hFFFE));
      @(posedge clk); #1;
      w_rvalid = 1'b0;
      #1;
      chk("t6_pc2", w_pc, 16'h0000);
      chk("t6_next2", w_next, 16'h0002);
      @(posedge clk); #1;
      w_ready = 1'b0;

      // Randomised stream with redirects and halt, checked against expected PCs
      do_reset();
      exp_pc = 16'h0000;
      hstate = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         g   = ($urandom % 4) != 0;
         rv  = (mq.size() != 0) && (($urandom % 3) != 0);
         rdy = ($urandom % 4) != 0;
         rd  = ($urandom % 40) == 0;
         if (($urandom % 50) == 0) hstate = ~hstate;
         r   = $urandom;
         rpc = r[15:0] & 16'hFFFE;
         cyc(g, rv, rdy, rd, rpc, hstate);
         if (s_ov && rdy) begin
            chk("rnd_pc", s_pc, exp_pc);
            chk("rnd_instr", s_instr, instr_of(exp_pc));
            chk("rnd_next", s_next, exp_pc + 16'h0002);
            exp_pc = exp_pc + 16'h0002;
         end
         if (rd) exp_pc = rpc;
      end

      // Reset mid-operation returns fetch to RESET_PC
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("rst_resume_req", s_req, 1'b1);
      chk("rst_resume_addr", s_addr, 16'h0000);
      chk("rst_resume_ov", s_ov, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
